// File: rtl/motor_pkg.sv
// ============================================================================
// motor_pkg : shared constants and state encoding for the move scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package motor_pkg;

  localparam int ANGLE_W       = 9;
  localparam int CNT_W         = 29;
  localparam int MAX_ANGLE_DEG = 359;
  localparam int CLK_HZ        = 50000000;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_ISSUE  = 3'd1;
  localparam logic [2:0] ENC_RUN    = 3'd2;
  localparam logic [2:0] ENC_SETTLE = 3'd3;
  localparam logic [2:0] ENC_FAULT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_ISSUE  = ENC_ISSUE,
    ST_RUN    = ENC_RUN,
    ST_SETTLE = ENC_SETTLE,
    ST_FAULT  = ENC_FAULT
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational 2-way round-robin arbiter; history kept by caller
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    // On a tie the requester not served last time wins.
    if (&req) gnt_id = ~last;
    else      gnt_id = req[1];
  end

endmodule

`default_nettype wire

// File: rtl/motor_move_sched.sv
// ============================================================================
// motor_move_sched : arbitrates two move requesters onto one stepper driver
// Rev 1.0
// ============================================================================
`default_nettype none

module motor_move_sched
  import motor_pkg::*;
#(
  parameter int SETTLE_CYC  = 2500000,
  parameter int TIMEOUT_CYC = 300000000,
  parameter int MAX_ANGLE   = MAX_ANGLE_DEG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               dir0,
  input  logic [ANGLE_W-1:0] angle0,
  output logic               ack0,
  input  logic               req1,
  input  logic               dir1,
  input  logic [ANGLE_W-1:0] angle1,
  output logic               ack1,
  output logic               m_en,
  output logic               m_dir,
  output logic [ANGLE_W-1:0] m_angle,
  input  logic               m_done,
  output logic               busy,
  output logic               grant_id,
  output logic               err_range,
  output logic               fault
);

  localparam int                 SETTLE_EFF  = (SETTLE_CYC > 1) ? SETTLE_CYC : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ANGLE_W-1:0] MAX_A       = ANGLE_W'(MAX_ANGLE);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               last, last_n;
  logic               m_en_n, m_dir_n, busy_n, grant_id_n;
  logic               ack0_n, ack1_n, err_range_n, fault_n;
  logic [ANGLE_W-1:0] m_angle_n;

  logic               gnt_id, gnt_valid;
  logic               sel_dir;
  logic [ANGLE_W-1:0] sel_angle;

  rr_arb2 u_arb (
    .req       ({req1, req0}),
    .last      (last),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      m_en      <= 1'b0;
      m_dir     <= 1'b0;
      m_angle   <= '0;
      busy      <= 1'b0;
      grant_id  <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err_range <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last      <= last_n;
      m_en      <= m_en_n;
      m_dir     <= m_dir_n;
      m_angle   <= m_angle_n;
      busy      <= busy_n;
      grant_id  <= grant_id_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
      err_range <= err_range_n;
      fault     <= fault_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_n      = last;
    m_en_n      = 1'b0;
    m_dir_n     = m_dir;
    m_angle_n   = m_angle;
    grant_id_n  = grant_id;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    err_range_n = 1'b0;
    fault_n     = fault;
    sel_dir     = gnt_id ? dir1 : dir0;
    sel_angle   = gnt_id ? angle1 : angle0;

    case (state)
      ST_IDLE: begin
        if (gnt_valid) begin
          m_dir_n    = sel_dir;
          m_angle_n  = sel_angle;
          grant_id_n = gnt_id;
          last_n     = gnt_id;
          if (sel_angle > MAX_A) begin
            err_range_n = 1'b1;
            ack0_n      = ~gnt_id;
            ack1_n      = gnt_id;
          end else if (sel_angle == '0) begin
            // A zero move would still cost the driver one step, so skip it.
            ack0_n = ~gnt_id;
            ack1_n = gnt_id;
          end else begin
            m_en_n  = 1'b1;
            state_n = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_n   = '0;
        state_n = ST_RUN;
      end
      ST_RUN: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (m_done) begin
          ack0_n  = ~grant_id;
          ack1_n  = grant_id;
          cnt_n   = '0;
          state_n = ST_SETTLE;
        end else if (cnt == TO_LAST) begin
          fault_n = 1'b1;
          ack0_n  = ~grant_id;
          ack1_n  = grant_id;
          state_n = ST_FAULT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        state_n = ST_FAULT;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_motor_move_sched.sv
// ============================================================================
// tb_motor_move_sched : scoreboard bench for the move scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_motor_move_sched;

  typedef struct packed {
    logic       en;
    logic       a0;
    logic       a1;
    logic       err;
    logic       dir;
    logic [8:0] ang;
    logic       gid;
    logic       busy;
    logic       flt;
  } sig_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, dir0, req1, dir1, m_done;
  logic [8:0] angle0, angle1;
  logic       ack0, ack1, m_en, m_dir, busy, grant_id, err_range, fault;
  logic [8:0] m_angle;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  suppress = 1'b0;
  int  exp_cyc[$];
  sig_t exp_sig[$];

  motor_move_sched #(
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (100),
    .MAX_ANGLE   (359)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .dir0      (dir0),
    .angle0    (angle0),
    .ack0      (ack0),
    .req1      (req1),
    .dir1      (dir1),
    .angle1    (angle1),
    .ack1      (ack1),
    .m_en      (m_en),
    .m_dir     (m_dir),
    .m_angle   (m_angle),
    .m_done    (m_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .err_range (err_range),
    .fault     (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic sig_t cur_sig();
    return {m_en, ack0, ack1, err_range, m_dir, m_angle, grant_id, busy, fault};
  endfunction

  function automatic sig_t mk(bit en, bit a0, bit a1, bit err, bit d,
                              logic [8:0] a, bit gid, bit b, bit f);
    return {en, a0, a1, err, d, a, gid, b, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, req);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input sig_t s);
    exp_cyc.push_back(c);
    exp_sig.push_back(s);
  endtask

  // Expected m_en and completion ack for a move accepted in IDLE at cycle n.
  task automatic push_move(input int n, input bit id, input bit d, input logic [8:0] a);
    push(n + 1,  mk(1'b1, 1'b0, 1'b0, 1'b0, d, a, id, 1'b1, 1'b0));
    push(n + 22, mk(1'b0, ~id, id, 1'b0, d, a, id, 1'b1, 1'b0));
  endtask

  // Monitor: every DUT event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (m_en || ack0 || ack1 || err_range)) begin
      if (exp_cyc.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event at cycle %0d: actual=0x%0h required=none", cyc, cur_sig());
      end else begin
        chk("event_cycle", cyc, exp_cyc.pop_front());
        chk("event_sig", cur_sig(), exp_sig.pop_front());
      end
    end
  end

  // Driver model: m_done 20 cycles after m_en, abandoned if reset intervenes.
  initial begin
    bit abort;
    m_done = 1'b0;
    forever begin
      @(negedge clk);
      if (m_en && !suppress) begin
        abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          if (rst) abort = 1'b1;
        end
        #1;
        if (!abort) begin
          m_done = 1'b1;
          @(posedge clk);
          #1;
          m_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog at cycle %0d: actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    req0 = 0; dir0 = 0; angle0 = '0;
    req1 = 0; dir1 = 0; angle1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", cur_sig(), '0);
    rst = 1'b0;
    at_cycle(cyc + 2);

    // Tie right after reset: requester 0 first, then 1 after settle.
    n = cyc;
    req0 = 1; dir0 = 0; angle0 = 9'd45;
    req1 = 1; dir1 = 0; angle1 = 9'd180;
    push_move(n, 1'b0, 1'b0, 9'd45);
    push_move(n + 26, 1'b1, 1'b0, 9'd180);
    at_cycle(n + 22); req0 = 0;
    at_cycle(n + 48); req1 = 0;
    at_cycle(n + 51); chk("busy_settle_tie", busy, 1);
    at_cycle(n + 52); chk("busy_idle_tie", busy, 0);
    at_cycle(n + 54);

    // Single move from requester 0.
    n = cyc;
    req0 = 1; dir0 = 1; angle0 = 9'd90;
    push_move(n, 1'b0, 1'b1, 9'd90);
    at_cycle(n + 22); req0 = 0;
    at_cycle(n + 25); chk("busy_settle_move", busy, 1);
    at_cycle(n + 26); chk("busy_idle_move", busy, 0);
    at_cycle(n + 28);

    // Out-of-range angle rejected.
    n = cyc;
    req1 = 1; dir1 = 1; angle1 = 9'd400;
    push(n + 1, mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'd400, 1'b1, 1'b0, 1'b0));
    at_cycle(n + 1); req1 = 0;
    at_cycle(n + 3); chk("busy_after_reject", busy, 0);

    // Zero angle skipped.
    n = cyc;
    req0 = 1; dir0 = 0; angle0 = 9'd0;
    push(n + 1, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0));
    at_cycle(n + 1); req0 = 0;
    at_cycle(n + 3); chk("busy_after_skip", busy, 0);

    // Tie with requester 0 served last: requester 1 first.
    n = cyc;
    req0 = 1; dir0 = 1; angle0 = 9'd10;
    req1 = 1; dir1 = 0; angle1 = 9'd20;
    push_move(n, 1'b1, 1'b0, 9'd20);
    push_move(n + 26, 1'b0, 1'b1, 9'd10);
    at_cycle(n + 22); req1 = 0;
    at_cycle(n + 48); req0 = 0;
    at_cycle(n + 54);

    // Reset in the middle of RUN.
    n = cyc;
    req0 = 1; dir0 = 1; angle0 = 9'd60;
    push(n + 1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'd60, 1'b0, 1'b1, 1'b0));
    at_cycle(n + 10);
    rst = 1'b1; req0 = 0;
    #1;
    chk("rst_midrun", cur_sig(), '0);
    at_cycle(n + 13); rst = 1'b0;
    at_cycle(n + 30);

    n = cyc;
    req0 = 1; dir0 = 0; angle0 = 9'd30;
    push_move(n, 1'b0, 1'b0, 9'd30);
    at_cycle(n + 22); req0 = 0;
    at_cycle(n + 28);

    // Driver never completes: fault 100 cycles into RUN, then terminal.
    suppress = 1'b1;
    n = cyc;
    req0 = 1; dir0 = 1; angle0 = 9'd50;
    push(n + 1,   mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'd50, 1'b0, 1'b1, 1'b0));
    push(n + 102, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd50, 1'b0, 1'b1, 1'b1));
    at_cycle(n + 101); chk("no_fault_yet", fault, 0);
    at_cycle(n + 102); req0 = 0;
    req1 = 1; dir1 = 0; angle1 = 9'd100;
    at_cycle(n + 132);
    chk("fault_terminal", {busy, fault}, 2'b11);
    req1 = 0;
    rst = 1'b1;
    #1;
    chk("fault_cleared", {busy, fault}, 2'b00);
    at_cycle(n + 135); rst = 1'b0;
    at_cycle(n + 137);

    chk("scoreboard_drained", exp_cyc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motor_move_sched.md
# motor_move_sched

Move scheduler in front of the four-phase stepper angle driver. Accepts relative-angle move requests from two independent requesters (e.g. key panel and UART command decoder) and arbitrates between them round-robin. Issues one move at a time to the driver and holds the command stable until the driver reports completion. Also enforces a settle gap between moves, filters illegal angles, and latches a fault if the driver never completes.

## Interface
- `SETTLE_CYC`, 2500000: idle gap after each move (50 ms at 50 MHz); values 0 and 1 both give a 1-cycle gap.
- `TIMEOUT_CYC`, 300000000: maximum cycles in RUN before fault; 29-bit counter.
- `MAX_ANGLE`, 359: largest legal angle, in degrees.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `req0` in 1: requester 0 move request; level, held until `ack0`.
- `dir0` in 1: requester 0 direction; stable while `req0`.
- `angle0` in 9: requester 0 angle in degrees; stable while `req0`.
- `ack0` out 1: one-cycle pulse; request 0 finished, rejected or skipped.
- `req1`, `dir1`, `angle1`, `ack1`: same as the requester 0 ports, for requester 1.
- `m_en` out 1: one-cycle start pulse to the driver.
- `m_dir` out 1: direction to the driver; held for the whole move.
- `m_angle` out 9: angle to the driver; held for the whole move.
- `m_done` in 1: driver completion pulse.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out 1: requester currently or last served.
- `err_range` out 1: one-cycle pulse; requested angle is greater than `MAX_ANGLE`.
- `fault` out 1: sticky; driver timeout occurred. Cleared only by `rst`.

## Operation
- States: IDLE, ISSUE, RUN, SETTLE, FAULT. Encoding is binary, 3 bits.
- IDLE: if any `req` is high, the arbiter picks a requester.
  - When both requests are high, the requester not equal to `last` wins. `last` resets to 1, so requester 0 wins the first tie.
  - The winner's dir/angle are captured into `m_dir`/`m_angle`, `grant_id` is updated, and `last` is updated to the winner.
  - angle > `MAX_ANGLE`: pulse that requester's ack and `err_range`; stay in IDLE; no move.
  - angle == 0: pulse ack only; stay in IDLE; no move. The driver would otherwise take one step.
  - Any other angle: go to ISSUE.
- ISSUE: `m_en`=1 for exactly one cycle, then go to RUN.
- RUN: the timeout counter increments every cycle. `m_dir`/`m_angle` stay frozen, because the driver re-samples angle continuously.
  - `m_done` seen: pulse the granted ack, clear the counter, go to SETTLE.
  - Counter reaches `TIMEOUT_CYC`-1 with no `m_done`: set `fault`, pulse the granted ack, go to FAULT.
- SETTLE: count `max(SETTLE_CYC,1)` cycles, then go to IDLE. Requests are ignored during SETTLE.
- FAULT: terminal state. No `m_en`, no acks, `busy`=1; requests are ignored.
- `m_done` outside RUN is ignored.
- A requester dropping `req` mid-move does not abort the move. The ack still pulses at completion.
- Simultaneous `m_done` and timeout expiry in the same cycle: `m_done` wins, no fault.

## Timing
- Reset values: every output is 0; state is IDLE; `last`=1; counters are 0.
- Reset asserted mid-move drops `m_en`, `m_dir` and `m_angle` to 0 immediately. The driver's own reset is expected in the same domain.
- All outputs are registered.
- `req` high in IDLE at cycle N:
  - `m_dir`, `m_angle`, `grant_id` and `busy` are valid at N+1, together with `m_en`=1.
  - RUN begins at N+2.
- Reject or skip: ack (and `err_range` if applicable) at N+1; `busy` stays 0.
- `m_done` at cycle M in RUN: ack at M+1, SETTLE from M+1 to M+SETTLE_CYC, IDLE at M+SETTLE_CYC+1.
- Earliest next `m_en` after `m_done` at M: M+SETTLE_CYC+2.
- Requests are accepted at one per IDLE visit; a requester must hold `req` at least until its ack.

## Structure
- Shared package `motor_pkg`:
  - state encoding localparams;
  - `MAX_ANGLE_DEG`=359;
  - `CLK_HZ`=50000000;
  - the angle width constant, 9.
- The driver uses the same angle width.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt_id`, `gnt_valid`.
  - Purely combinational; `last` is held in the scheduler.
- The FSM, the timeout counter and the settle counter live in `motor_move_sched`. A single 29-bit counter is shared between RUN and SETTLE.

## Test plan
Sim parameters: `SETTLE_CYC`=4, `TIMEOUT_CYC`=100. Behavioral driver model pulses `m_done` 20 cycles after `m_en`.

- `req0`=1, `dir0`=1, `angle0`=90 → `m_en` pulse 1 cycle later with `m_angle`=90 and `m_dir`=1; `ack0` 21 cycles after `m_en`; `busy` falls 4 cycles after `ack0`.
- `req0` and `req1` rise in the same cycle (angles 45 and 180) → requester 0 is served first; `ack0`; after settle, `m_angle`=180 and `grant_id`=1; `ack1` last.
- `angle1`=400 → `ack1` and `err_range` 1 cycle later; no `m_en`; `busy` stays 0.
- `angle0`=0 → `ack0` 1 cycle later; no `m_en`; no `err_range`.
- Driver model suppresses `m_done` → `fault`=1 and `ack0` 100 cycles into RUN; later requests get no `m_en` and no ack until `rst`.
- `rst` asserted mid-RUN → outputs go to 0 immediately; after release, a new `req0` with angle 30 issues a normal move.
